// File: rtl/fifo_burst_reader.sv
// Burst read engine draining a FIFO read port into a valid/ready stream via a 2-entry buffer.
// Optional FIFO_BURST_READER_CHECKSUM_EN adds checksum_o (XOR of words transferred in the burst).
module fifo_burst_reader #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LEN_WIDTH = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [LEN_WIDTH-1:0] count_o,
  output logic                 rd_en_o,
  input  logic                 empty_i,
  input  logic [WIDTH-1:0]     rdata_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i
`ifdef FIFO_BURST_READER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum_o
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] received_q, received_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [1:0]           occ_q, occ_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d;
  logic [WIDTH-1:0]     buf1_q, buf1_d;
  logic                 inflight_q;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 zerr_q, zerr_d;
  logic [WIDTH-1:0]     cks_q, cks_d;

  logic       start_ok;
  logic       pop;
  logic       wr;
  logic       rd_en;
  logic       tmo_inc;
  logic       tmo_hit;
  logic [2:0] occ_after;

  assign start_ok  = (state_q == S_IDLE) && start_i && (len_i != '0);
  assign pop       = (occ_q != 2'd0) && m_ready_i;
  assign wr        = inflight_q;
  assign tmo_inc   = (state_q == S_READ) && empty_i && (issued_q < len_q);
  assign tmo_hit   = tmo_inc && (tmo_q == TW'(TIMEOUT - 1));
  // Occupancy once the in-flight word lands and this cycle's pop leaves.
  assign occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    rd_en = (state_q == S_READ) && !empty_i && (issued_q < len_q) && (occ_after <= 3'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_READ;
      S_READ: begin
        if (tmo_hit)                  state_d = S_ABORT;
        else if (issued_q == len_q)   state_d = S_DRAIN;
      end
      S_DRAIN: if ((received_q == len_q) && (occ_d == 2'd0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_DONE);
    error_o   = (state_q == S_ABORT) || zerr_q;
    count_o   = count_q;
    rd_en_o   = rd_en;
    m_data_o  = buf0_q;
    m_valid_o = (occ_q != 2'd0);
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    checksum_o = cks_q;
`endif
  end

  always_comb begin
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    count_d    = count_q;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    tmo_d      = tmo_q;
    cks_d      = cks_q;
    zerr_d     = (state_q == S_IDLE) && start_i && (len_i == '0);

    if (start_ok) begin
      len_d      = len_i;
      issued_d   = '0;
      received_d = '0;
      count_d    = '0;
      tmo_d      = '0;
      cks_d      = '0;
    end else begin
      if (rd_en) issued_d = issued_q + 1'b1;
      if (wr)    received_d = received_q + 1'b1;
      if (pop) begin
        count_d = (count_q == len_q) ? count_q : count_q + 1'b1;
        cks_d   = cks_q ^ buf0_q;
      end
      if (state_q == S_READ) begin
        if (!empty_i)     tmo_d = '0;
        else if (tmo_inc) tmo_d = tmo_q + 1'b1;
      end
    end

    // Head is buf0; a simultaneous write and pop shifts before appending.
    unique case ({wr, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = rdata_i;
        else               buf1_d = rdata_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = rdata_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rdata_i;
        end
      end
      default: ;
    endcase

    if (tmo_hit) occ_d = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      count_q    <= '0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      inflight_q <= 1'b0;
      tmo_q      <= '0;
      zerr_q     <= 1'b0;
      cks_q      <= '0;
    end else begin
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      count_q    <= count_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      inflight_q <= rd_en;
      tmo_q      <= tmo_d;
      zerr_q     <= zerr_d;
      cks_q      <= cks_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: queue-based FIFO model, expected words queued per burst.
module tb_fifo_burst_reader;

  localparam int W  = 4;
  localparam int LW = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, error_o, rd_en_o, m_valid_o;
  logic [LW-1:0] count_o;
  logic          empty_i = 1'b1;
  logic [W-1:0]  rdata_i = '0;
  logic [W-1:0]  m_data_o;
  logic          m_ready_i = 1'b1;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
  logic [W-1:0]  checksum_o;
  logic [W-1:0]  ck_at_done;
`endif

  fifo_burst_reader #(.WIDTH(W), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .count_o(count_o),
    .rd_en_o(rd_en_o), .empty_i(empty_i), .rdata_i(rdata_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rmode = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_xor;
  logic         rd_en_n = 1'b0;

  int rd_cnt, first_rd, last_rd, xfer_cnt, first_xfer, last_xfer, first_valid;
  int done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, empty_rise, burst_t0;
  logic         stall_prev = 1'b0;
  logic         empty_prev = 1'b1;
  logic [W-1:0] stall_data = '0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    rd_cnt = 0; first_rd = -1; last_rd = -1;
    xfer_cnt = 0; first_xfer = -1; last_xfer = -1; first_valid = -1;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    busy_cnt = 0; empty_rise = -1;
  endtask

  task automatic load_seq(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'((base + i) % 16));
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: registered read data, one cycle after the pop request.
  always @(posedge clk) begin
    if (rd_en_n && fifo_q.size() != 0) rdata_i <= fifo_q.pop_front();
    empty_i <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = ~m_ready_i;
      default: m_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    rd_en_n = rd_en_o;
    if (rd_en_o === 1'b1) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      check(empty_i == 1'b0, "pop_while_empty", int'(empty_i), 0);
    end
    if (stall_prev && !rst_i)
      check(m_valid_o === 1'b1 && m_data_o == stall_data, "stream_hold",
            int'(m_data_o), int'(stall_data));
    if (m_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
    if (m_valid_o === 1'b1 && m_ready_i) begin
      xfer_cnt++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (exp_q.size() == 0) check(1'b0, "unexpected_word", int'(m_data_o), -1);
      else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check(m_data_o == e, "word_data", int'(m_data_o), int'(e));
      end
    end
    stall_prev = (m_valid_o === 1'b1) && !m_ready_i && !rst_i;
    stall_data = m_data_o;
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
      ck_at_done = checksum_o;
`endif
    end
    if (error_o === 1'b1) begin err_cnt++; err_cyc = cyc; end
    if (busy_o === 1'b1) busy_cnt++;
    if (busy_o === 1'b1 && empty_i && !empty_prev && empty_rise < 0) empty_rise = cyc;
    empty_prev = empty_i;
  end

  task automatic run_burst(input int n, input int exp_words, input bit exp_done, input bit hold);
    int guard;
    exp_q.delete();
    exp_xor = '0;
    for (int i = 0; i < exp_words; i++) begin
      exp_q.push_back(fifo_q[i]);
      exp_xor ^= fifo_q[i];
    end
    clr_stats();
    start_i = 1'b1;
    len_i   = LW'(n);
    step();
    burst_t0 = cyc;
    if (hold) len_i = LW'(2);
    else      start_i = 1'b0;
    guard = 0;
    while (busy_o && guard < 3000) begin
      if (hold && done_o) start_i = 1'b0;
      step();
      guard++;
    end
    start_i = 1'b0;
    if (guard >= 3000) check(1'b0, "burst_timeout", guard, 3000);
    step();
    step();
    check(done_cnt == int'(exp_done), "done_pulses", done_cnt, int'(exp_done));
    check(err_cnt == int'(!exp_done), "error_pulses", err_cnt, int'(!exp_done));
    check(exp_q.size() == 0, "words_missing", exp_q.size(), 0);
    check(xfer_cnt == exp_words, "transfers", xfer_cnt, exp_words);
    check(int'(count_o) == exp_words, "count_o", int'(count_o), exp_words);
    check(busy_o == 1'b0, "busy_after", int'(busy_o), 0);
    if (exp_done) begin
      check(done_cyc == last_xfer + 1, "done_timing", done_cyc, last_xfer + 1);
`ifdef FIFO_BURST_READER_CHECKSUM_EN
      check(ck_at_done == exp_xor, "checksum", int'(ck_at_done), int'(exp_xor));
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=%0d expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, extra;
    clr_stats();
    repeat (3) step();
    check(busy_o == 0 && done_o == 0 && error_o == 0 && rd_en_o == 0 && m_valid_o == 0
          && count_o == '0 && m_data_o == '0, "reset_state", int'(m_valid_o), 0);
    rst_i = 1'b0;
    step();

    // Full-rate burst of 16 prefilled words
    fifo_q.delete();
    load_seq(16, 0);
    rmode = 0;
    step(); step();
    run_burst(16, 16, 1'b1, 1'b0);
    check(first_rd == burst_t0, "first_rd_en_cycle", first_rd - burst_t0, 0);
    check(first_valid == burst_t0 + 2, "first_valid_cycle", first_valid - burst_t0, 2);
    check(rd_cnt == 16, "rd_en_count", rd_cnt, 16);
    check(last_rd - first_rd == 15, "rd_en_contiguous", last_rd - first_rd, 15);
    check(last_xfer - first_xfer == 15, "xfer_contiguous", last_xfer - first_xfer, 15);

    // Reset held while idle with a start request and a non-empty FIFO
    fifo_q.delete();
    load_seq(5, 3);
    step(); step();
    clr_stats();
    rst_i = 1'b1; start_i = 1'b1; len_i = LW'(3);
    for (int i = 0; i < 5; i++) begin
      step();
      check(rd_en_o == 0 && busy_o == 0 && done_o == 0 && error_o == 0 && m_valid_o == 0
            && count_o == '0 && m_data_o == '0, "reset_idle_outputs", int'(rd_en_o), 0);
    end
    start_i = 1'b0; rst_i = 1'b0;
    step(); step();
    check(busy_cnt == 0 && rd_cnt == 0, "reset_no_activity", busy_cnt + rd_cnt, 0);

    // Toggling backpressure
    fifo_q.delete();
    load_seq(8, 5);
    rmode = 1;
    step(); step();
    run_burst(8, 8, 1'b1, 1'b0);
    rmode = 0;

    // FIFO runs dry: empty timeout abort
    fifo_q.delete();
    load_seq(3, 9);
    step(); step();
    run_burst(5, 3, 1'b0, 1'b0);
    check(err_cyc - empty_rise == TO, "timeout_latency", err_cyc - empty_rise, TO);

    // Zero-length request
    fifo_q.delete();
    load_seq(2, 4);
    step(); step();
    clr_stats();
    start_i = 1'b1; len_i = '0;
    step();
    burst_t0 = cyc;
    start_i = 1'b0;
    repeat (3) step();
    check(err_cnt == 1, "len0_error_pulses", err_cnt, 1);
    check(err_cyc == burst_t0, "len0_error_cycle", err_cyc - burst_t0, 0);
    check(rd_cnt == 0 && busy_cnt == 0, "len0_no_pop", rd_cnt + busy_cnt, 0);

    // start_i held high through a busy burst is ignored
    fifo_q.delete();
    load_seq(8, 0);
    step(); step();
    run_burst(4, 4, 1'b1, 1'b1);
    check(fifo_q.size() == 4, "busy_start_ignored", fifo_q.size(), 4);

    // Reset in the middle of a burst
    fifo_q.delete();
    load_seq(8, 8);
    step(); step();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(fifo_q[i]);
    clr_stats();
    start_i = 1'b1; len_i = LW'(8);
    step();
    start_i = 1'b0;
    n = 0;
    while (xfer_cnt < 4 && n < 100) begin step(); n++; end
    check(n < 100, "mid_burst_wait", n, 100);
    rst_i = 1'b1;
    step();
    check(rd_en_o == 0 && m_valid_o == 0, "reset_mid_burst", int'(rd_en_o) + int'(m_valid_o), 0);
    step(); step();
    check(count_o == '0 && busy_o == 0, "reset_mid_count", int'(count_o), 0);
    check(done_cnt == 0 && err_cnt == 0, "reset_no_pulse", done_cnt + err_cnt, 0);
    rst_i = 1'b0;
    fifo_q.delete();
    load_seq(4, 1);
    step(); step();
    run_burst(4, 4, 1'b1, 1'b0);

    // Randomized bursts with random backpressure
    rmode = 2;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 31);
      extra = $urandom_range(0, 3);
      fifo_q.delete();
      for (int i = 0; i < n + extra; i++) fifo_q.push_back(W'($urandom_range(0, 15)));
      step(); step();
      run_burst(n, n, 1'b1, 1'b0);
      check(fifo_q.size() == extra, "rand_leftover", fifo_q.size(), extra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
